btn_irq_ctrl: RTL and testbench

- Sits directly downstream of the per-button debouncers.
- Collects their single-cycle debounced press ticks into sticky pending bits.
- Arbitrates among enabled pending sources and raises one interrupt request with a source ID to the RISC interrupt handler.
- Holds each request until acknowledged, then clears that source; one request is in flight at a time.

---
 rtl/btn_irq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_btn_irq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_irq_ctrl.sv
// btn_irq_ctrl
// Interrupt front end for the debounced push buttons. Each single-cycle press
// tick is caught in a sticky pending bit. One enabled pending source is
// arbitrated and presented to the RISC handler as a request plus source ID.
// The request is held until the handler acknowledges it, which clears that
// source's pending bit. A press that arrives while the source is still pending
// is recorded as an overrun.
//
// Ports:
//   clk_50MHz  in   system clock
//   rst_n      in   asynchronous active-low reset
//   db_tick_i  in   [NUM_SRC] debounced press ticks, one cycle wide
//   irq_en_i   in   [NUM_SRC] per-source request enable
//   irq_ack_i  in   handler acknowledge (level)
//   ovr_clr_i  in   one-cycle pulse, clears every overrun flag
//   irq_o      out  interrupt request
//   irq_id_o   out  [ID_W] requesting source, valid while irq_o=1
//   pend_o     out  [NUM_SRC] raw pending bits (not masked)
//   ovr_o      out  [NUM_SRC] sticky overrun flags
//
// Build option:
//   BTN_IRQ_ROUND_ROBIN_EN - round-robin arbitration using a last-grant pointer.
//                            When undefined, the lowest pending index wins.

module btn_irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] db_tick_i,
    input  logic [NUM_SRC-1:0] irq_en_i,
    input  logic               irq_ack_i,
    input  logic               ovr_clr_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_SRC-1:0] pend_o,
    output logic [NUM_SRC-1:0] ovr_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] ovr_q, ovr_d;
    logic               ack_q;

    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic [ID_W-1:0]    win_id;
    logic               ack_rise;
    logic               served;

    assign req_vec = pend_q & irq_en_i;

    // Only a fresh rising ack consumes a request: an ack that was already high
    // when the request appeared belongs to an earlier (or spurious) cycle.
    assign ack_rise = irq_ack_i & ~ack_q;
    assign served   = (state_q == ST_REQ) & ack_rise;

    always_comb begin
        clr_vec = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            clr_vec[k] = served & (id_q == ID_W'(k));
        end
    end

`ifdef BTN_IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Pick the requester nearest after the last grant, measured as a
    // circular distance starting at ptr+1.
    always_comb begin
        int dist;
        int best;
        win_id = '0;
        best   = NUM_SRC;
        dist   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            dist = k - int'(ptr_q) - 1;
            if (dist < 0) begin
                dist = dist + NUM_SRC;
            end
            if (req_vec[k] && (dist < best)) begin
                best   = dist;
                win_id = ID_W'(k);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == ST_IDLE) && (|req_vec)) begin
            ptr_d = win_id;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Descending scan so the lowest requesting index is the final assignment.
    always_comb begin
        win_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req_vec[k]) begin
                win_id = ID_W'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    irq_d   = 1'b1;
                    id_d    = win_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (served) begin
                    irq_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Wait for the handler to release ack so one long ack cannot
                // retire a second request.
                if (!irq_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A tick on the source being cleared re-arms it without counting as overrun.
    always_comb begin
        pend_d = (pend_q & ~clr_vec) | db_tick_i;
        ovr_d  = (ovr_clr_i ? '0 : ovr_q) | (db_tick_i & pend_q & ~clr_vec);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ack_q   <= irq_ack_i;
        end
    end

    assign irq_o    = irq_q;
    assign irq_id_o = id_q;
    assign pend_o   = pend_q;
    assign ovr_o    = ovr_q;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
module tb_btn_irq_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  tick;
    logic [N-1:0]  en;
    logic          ack;
    logic          oclr;
    logic          irq;
    logic [IW-1:0] id;
    logic [N-1:0]  pend;
    logic [N-1:0]  ovr;

    always #10 clk = ~clk;

    btn_irq_ctrl #(.NUM_SRC(N), .ID_W(IW)) dut (
        .clk_50MHz (clk),
        .rst_n     (rst_n),
        .db_tick_i (tick),
        .irq_en_i  (en),
        .irq_ack_i (ack),
        .ovr_clr_i (oclr),
        .irq_o     (irq),
        .irq_id_o  (id),
        .pend_o    (pend),
        .ovr_o     (ovr)
    );

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: handler-visible behaviour expressed as flags.
    bit [N-1:0] m_pend;
    bit [N-1:0] m_ovr;
    bit         m_irq;
    bit         m_wait_release;
    bit         m_ack_prev;
    int         m_id;
    int         m_ptr;

    function automatic int pick(input bit [N-1:0] cand, input int ptr);
`ifdef BTN_IRQ_ROUND_ROBIN_EN
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (cand[idx]) return idx;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (cand[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_asrt++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_ovr = '0;
        m_irq = 1'b0;
        m_wait_release = 1'b0;
        m_ack_prev = 1'b0;
        m_id = 0;
        m_ptr = 0;
    endtask

    task automatic model_step();
        bit served;
        bit [N-1:0] clr;
        bit [N-1:0] cand;
        bit [N-1:0] np;
        served = m_irq && ack && !m_ack_prev;
        clr    = served ? N'(1 << m_id) : '0;
        cand   = m_pend & en;
        np     = (m_pend & ~clr) | tick;
        m_ovr  = (oclr ? '0 : m_ovr) | (tick & m_pend & ~clr);
        if (m_irq) begin
            if (served) begin
                m_irq = 1'b0;
                m_wait_release = 1'b1;
            end
        end else if (m_wait_release) begin
            if (!ack) m_wait_release = 1'b0;
        end else if (cand != 0) begin
            m_id  = pick(cand, m_ptr);
            m_ptr = m_id;
            m_irq = 1'b1;
        end
        m_pend = np;
        m_ack_prev = ack;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("irq_model", irq, m_irq);
        chk("pend_model", pend, m_pend);
        chk("ovr_model", ovr, m_ovr);
        if (m_irq) chk("id_model", id, m_id);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_pend", pend, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_id", id, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int want_ord [5];
        int w;
        tick = '0;
        en   = 4'b1111;
        ack  = 1'b0;
        oclr = 1'b0;
        do_reset();

        // Reset behaviour and latency
        tick = 4'b0100;
        cycle();
        chk("t1_pend", pend, 4'b0100);
        chk("t1_irq_early", irq, 0);
        tick = '0;
        cycle();
        chk("t1_irq", irq, 1);
        chk("t1_id", id, 2);
        #3;
        do_reset();

        // Fixed priority, long ack
        tick = 4'b1010;
        cycle();
        tick = '0;
        cycle();
        chk("t2_id", id, 1);
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_hold_irq", irq, 0);
            chk("t2_hold_pend", pend, 4'b1000);
        end
        ack = 1'b0;
        cycle();
        chk("t2_idle_irq", irq, 0);
        cycle();
        chk("t2_next_irq", irq, 1);
        chk("t2_next_id", id, 3);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        cycle();

        // Masked source
        en = 4'b1110;
        tick = 4'b0001;
        cycle();
        tick = '0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("t3_masked_irq", irq, 0);
        end
        chk("t3_pend0", pend[0], 1);
        en = 4'b1111;
        cycle();
        chk("t3_irq", irq, 1);
        chk("t3_id", id, 0);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        cycle();

        // Overrun and same-cycle tick/ack
        tick = 4'b0100;
        cycle();
        tick = '0;
        cycle();
        chk("t4_id", id, 2);
        tick = 4'b0100;
        cycle();
        chk("t4_ovr", ovr, 4'b0100);
        ack = 1'b1;
        cycle();
        chk("t4_ack_pend", pend, 4'b0100);
        chk("t4_ack_ovr", ovr, 4'b0100);
        chk("t4_ack_irq", irq, 0);
        tick = '0;
        ack = 1'b0;
        cycle();
        cycle();
        chk("t4_again_irq", irq, 1);
        chk("t4_again_id", id, 2);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        cycle();
        oclr = 1'b1;
        cycle();
        chk("t4_ovr_clr", ovr, 0);
        oclr = 1'b0;

        // Spurious ack
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_spur_irq", irq, 0);
            chk("t5_spur_pend", pend, 0);
        end
        tick = 4'b0010;
        cycle();
        tick = '0;
        cycle();
        chk("t5_irq", irq, 1);
        chk("t5_id", id, 1);
        cycle();
        cycle();
        chk("t5_not_consumed", irq, 1);
        chk("t5_still_pend", pend, 4'b0010);
        ack = 1'b0;
        cycle();
        chk("t5_irq_low_ack", irq, 1);
        ack = 1'b1;
        cycle();
        chk("t5_consumed_irq", irq, 0);
        chk("t5_consumed_pend", pend, 0);
        ack = 1'b0;
        cycle();

        // Grant order with all sources kept pending
        #3;
        do_reset();
`ifdef BTN_IRQ_ROUND_ROBIN_EN
        want_ord = '{1, 2, 3, 0, 1};
`else
        want_ord = '{0, 0, 0, 0, 0};
`endif
        tick = 4'b1111;
        cycle();
        tick = '0;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (!irq && w < 10) begin
                cycle();
                w++;
            end
            chk("t6_wait", irq, 1);
            chk("t6_grant", id, want_ord[g]);
            ack = 1'b1;
            tick = N'(1 << id);
            cycle();
            tick = '0;
            ack = 1'b0;
            cycle();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            tick = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) en = N'($urandom);
            if ($urandom_range(0, 2) == 0) ack = ~ack;
            oclr = ($urandom_range(0, 19) == 0);
            if (i == 200) begin
                #3;
                do_reset();
            end
            cycle();
        end

        tick = '0;
        ack = 1'b0;
        oclr = 1'b0;
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
